vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/RGB timing generator and pixel output stage, the successor to the fixed 1024x768 driver. It adds fully parametrised timing, selectable sync polarity, a configurable upstream read latency with aligned output pipeline, and zero-based pixel coordinates. It also adds a frame-synchronous mode select for pass-through, colour bars, solid fill or black. It sits between the SDRAM read FIFO (pixel source) and the VGA pins.

Parameters:
PIX_W, 16, pixel width; legal values are 16 (RGB565) and 24 (RGB888).
H_SYNC, 136, hsync width in clocks.
H_BACK, 160, horizontal back porch.
H_DISP, 1024, active pixels per line.
H_FRONT, 24, horizontal front porch.
V_SYNC, 6, vsync width in lines.
V_BACK, 29, vertical back porch.
V_DISP, 768, active lines.
V_FRONT, 3, vertical front porch.
HS_POL, 0, hsync active level (0 = active low).
VS_POL, 0, vsync active level.
RD_LAT, 1, pixel source read latency in clocks (1..3).
CNT_W, 12, counter and coordinate width.

Ports:
vga_clk  in  1  pixel clock.
sys_rst_n  in  1  asynchronous active-low reset.
mode  in  2  0 = pass-through, 1 = colour bars, 2 = solid fill, 3 = black.
fill_color  in  PIX_W  colour used in mode 2.
pixel_data  in  PIX_W  source pixel; valid RD_LAT clocks after the matching data_req cycle.
data_req  out  1  pixel request, one per active pixel.
pixel_xpos  out  CNT_W  column of the current request, 0..H_DISP-1.
pixel_ypos  out  CNT_W  row of the current request, 0..V_DISP-1.
frame_start  out  1  one-cycle pulse at the start of each frame.
vga_hs  out  1  horizontal sync.
vga_vs  out  1  vertical sync.
vga_de  out  1  display enable.
vga_rgb  out  PIX_W  pixel output.

Behaviour:
- One clock, vga_clk. Reset sys_rst_n is asynchronous and active-low.
- Derived constants: H_TOTAL = sum of the H_* timing parameters; V_TOTAL = sum of the V_* timing parameters. Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^CNT_W, if RD_LAT is outside 1..3, or if PIX_W is not 16 or 24.
- Counters:
  - cnt_h runs 0..H_TOTAL-1 and wraps to 0.
  - cnt_v increments when cnt_h = H_TOTAL-1 and wraps to 0 after V_TOTAL-1.
- Active region: cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- Stage 1 (registered from the counters):
  - data_req = active region AND active_mode == 0.
  - pixel_xpos = cnt_h - (H_SYNC+H_BACK) when the position is active, else 0. pixel_ypos is computed the same way from cnt_v.
  - frame_start = 1 when the counters are at (0,0).
- Timing pipeline: the raw hs, vs, de and coordinates are delayed by RD_LAT further stages. vga_hs, vga_vs, vga_de and vga_rgb are all registered and mutually aligned.
  - vga_de rises exactly RD_LAT+1 clocks after the first data_req of each line.
  - vga_rgb on the k-th vga_de cycle of a line equals the pixel_data returned for the k-th request.
- Sync outputs: vga_hs is at HS_POL for H_SYNC clocks per line and at ~HS_POL otherwise. vga_vs is at VS_POL for V_SYNC full lines per frame.
- vga_rgb selection:
  - Blanking (vga_de = 0): always 0.
  - Mode 0: pixel_data.
  - Mode 1: bar index = xpos / (H_DISP/8), with xpos taken from the delayed pipeline. The last bar absorbs any remainder. Colours in order are white, yellow, cyan, green, magenta, red, blue, black; RGB565 values FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, with RGB888 equivalents.
  - Mode 2: fill_color.
  - Mode 3: 0.
- Mode latching: mode is sampled into active_mode only in the cycle where cnt_h = H_TOTAL-1 and cnt_v = V_TOTAL-1. A change mid-frame therefore takes effect from the next frame. fill_color is sampled at the same point.
- Reset values, all applied immediately and asynchronously:
  - cnt_h, cnt_v, active_mode and the pipeline registers = 0.
  - data_req, vga_de, frame_start = 0; pixel_xpos, pixel_ypos, vga_rgb = 0.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL.
- After reset release, the first rising edge registers frame_start = 1.
- Reset asserted mid-frame: outputs return to their reset values at once, and the frame restarts from (0,0) on release. No partial line is emitted.

Decomposition:
- Package vga_pkg holds:
  - the bar colour constants for RGB565 and RGB888;
  - the mode encodings (MODE_PASS, MODE_BARS, MODE_FILL, MODE_BLACK);
  - a 1024x768@65 MHz default timing set.
- One sub-module, vga_delay_line: a parametrised DEPTH x WIDTH register shift line with async reset and a per-bit reset value. It is used to align hs, vs, de and xpos to the RD_LAT latency.

Test Plan:
1. Small timing (H 4/4/16/4, V 2/2/8/2), mode 0, default polarity -> hs low 4 of every 28 clocks; vs low for 56 clocks of every 392; frame_start pulses every 392 clocks; 128 data_req per frame.
2. Mode 0, RD_LAT=1, source model returns x + 16*y one clock after each request -> first active line vga_rgb = 0..15; vga_de rises 2 clocks after data_req; pixel_xpos/pixel_ypos span 0..15 and 0..7.
3. RD_LAT=3 -> vga_de rises 4 clocks after data_req; data alignment is unchanged.
4. Switch mode 0->1 mid-frame -> the current frame stays pass-through; the next frame shows bars 2 pixels wide, FFFF,FFFF,FFE0,FFE0,...,0000; data_req stays low throughout that frame.
5. Mode 2, fill_color=16'h1234 -> vga_rgb = 1234 only while vga_de is high, 0 in blanking. HS_POL=VS_POL=1 -> sync levels inverted.
6. sys_rst_n pulled low mid active line -> all outputs take their reset values in the same cycle; after release, frame_start fires on the first edge and the timing of test 1 repeats exactly.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - output mode encodings (vga_mode_e)
//   - default 1024x768 @ 65 MHz timing set
//   - colour-bar palette lookups for RGB565 and RGB888
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_FILL  = 2'd2,
        MODE_BLACK = 2'd3
    } vga_mode_e;

    // 1024x768 @ 65 MHz pixel clock
    localparam int XGA_H_SYNC  = 136;
    localparam int XGA_H_BACK  = 160;
    localparam int XGA_H_DISP  = 1024;
    localparam int XGA_H_FRONT = 24;
    localparam int XGA_V_SYNC  = 6;
    localparam int XGA_V_BACK  = 29;
    localparam int XGA_V_DISP  = 768;
    localparam int XGA_V_FRONT = 3;

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_rgb565(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            3'd7:    c = 16'h0000;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] bar_rgb888(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage register shift line, WIDTH bits wide, with asynchronous
// active-low reset to a per-bit value RST_VAL.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   d_i    : word entering the line
//   q_o    : word delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the word one stage per clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator and pixel output stage.
//   vga_clk     : pixel clock
//   sys_rst_n   : asynchronous active-low reset
//   mode        : output mode, latched once per frame (pass/bars/fill/black)
//   fill_color  : solid colour for fill mode, latched with mode
//   pixel_data  : source pixel, valid RD_LAT clocks after its data_req
//   data_req    : one request per active pixel (pass-through mode only)
//   pixel_xpos  : zero-based column of the current request
//   pixel_ypos  : zero-based row of the current request
//   frame_start : one-cycle pulse when the raster is at (0,0)
//   vga_hs/vs   : sync outputs, polarity set by HS_POL/VS_POL
//   vga_de      : display enable, aligned with vga_rgb
//   vga_rgb     : pixel output, zero during blanking
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int PIX_W   = 16,
    parameter int H_SYNC  = 136,
    parameter int H_BACK  = 160,
    parameter int H_DISP  = 1024,
    parameter int H_FRONT = 24,
    parameter int V_SYNC  = 6,
    parameter int V_BACK  = 29,
    parameter int V_DISP  = 768,
    parameter int V_FRONT = 3,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int RD_LAT  = 1,
    parameter int CNT_W   = 12
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] fill_color,
    input  logic [PIX_W-1:0] pixel_data,
    output logic             data_req,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [PIX_W-1:0] vga_rgb
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_cnt
        $error("vga_timing_gen: raster does not fit in CNT_W bits");
    end
    if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_lat
        $error("vga_timing_gen: RD_LAT must be 1..3");
    end
    if ((PIX_W != 16) && (PIX_W != 24)) begin : g_bad_pix
        $error("vga_timing_gen: PIX_W must be 16 or 24");
    end
    if (H_DISP < 8) begin : g_bad_disp
        $error("vga_timing_gen: H_DISP must hold at least 8 bars");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA_FIRST = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HA_LAST  = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [CNT_W-1:0] VA_FIRST = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VA_LAST  = CNT_W'(V_SYNC + V_BACK + V_DISP - 1);
    localparam logic [CNT_W-1:0] HS_LEN   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_LEN   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_DISP / 8);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BAR_MAX  = CNT_W'(32'd7);
    localparam int               DLY_W    = CNT_W + 3;

    logic [CNT_W-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
    vga_mode_e        active_mode_q;
    logic [PIX_W-1:0] fill_q;
    logic             frame_end_s, act_s;

    logic             data_req_q, data_req_d;
    logic [CNT_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic             frame_start_q, frame_start_d;
    logic             hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;

    logic [DLY_W-1:0] dly_s;
    logic             hs_dly_s, vs_dly_s, de_dly_s;
    logic [CNT_W-1:0] x_dly_s, bar_q_s;
    logic [2:0]       bar_idx_s;
    logic [PIX_W-1:0] bar_s;

    logic             vga_hs_q, vga_vs_q, vga_de_q;
    logic [PIX_W-1:0] vga_rgb_q, vga_rgb_d;

    assign frame_end_s = (cnt_h_q == H_LAST) && (cnt_v_q == V_LAST);
    assign act_s = (cnt_h_q >= HA_FIRST) && (cnt_h_q <= HA_LAST) &&
                   (cnt_v_q >= VA_FIRST) && (cnt_v_q <= VA_LAST);

    // Raster counter next state
    always_comb begin
        cnt_h_d = cnt_h_q + CNT_ONE;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST) begin
            cnt_h_d = '0;
            if (cnt_v_q == V_LAST) begin
                cnt_v_d = '0;
            end else begin
                cnt_v_d = cnt_v_q + CNT_ONE;
            end
        end else begin
            cnt_h_d = cnt_h_q + CNT_ONE;
        end
    end

    // Raster counters plus mode/fill latched only on the last pixel of a frame
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            active_mode_q <= MODE_PASS;
            fill_q        <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            if (frame_end_s) begin
                active_mode_q <= vga_mode_e'(mode);
                fill_q        <= fill_color;
            end else begin
                active_mode_q <= active_mode_q;
                fill_q        <= fill_q;
            end
        end
    end

    // Stage-1 decode of the counter position
    always_comb begin
        data_req_d = 1'b0;
        xpos_d     = '0;
        ypos_d     = '0;
        de_s1_d    = 1'b0;
        if (act_s) begin
            de_s1_d    = 1'b1;
            data_req_d = (active_mode_q == MODE_PASS);
            xpos_d     = cnt_h_q - HA_FIRST;
            ypos_d     = cnt_v_q - VA_FIRST;
        end else begin
            de_s1_d    = 1'b0;
            data_req_d = 1'b0;
        end
        hs_s1_d       = (cnt_h_q < HS_LEN) ? HS_POL : ~HS_POL;
        vs_s1_d       = (cnt_v_q < VS_LEN) ? VS_POL : ~VS_POL;
        frame_start_d = (cnt_h_q == '0) && (cnt_v_q == '0);
    end

    // Stage-1 registers
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_req_q    <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            frame_start_q <= 1'b0;
            hs_s1_q       <= ~HS_POL;
            vs_s1_q       <= ~VS_POL;
            de_s1_q       <= 1'b0;
        end else begin
            data_req_q    <= data_req_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            frame_start_q <= frame_start_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            de_s1_q       <= de_s1_d;
        end
    end

    // Holds sync, enable and column back until the requested pixel returns
    vga_delay_line #(
        .DEPTH   (RD_LAT),
        .WIDTH   (DLY_W),
        .RST_VAL ({~HS_POL, ~VS_POL, 1'b0, {CNT_W{1'b0}}})
    ) u_align (
        .clk_i  (vga_clk),
        .rst_ni (sys_rst_n),
        .d_i    ({hs_s1_q, vs_s1_q, de_s1_q, xpos_q}),
        .q_o    (dly_s)
    );

    assign {hs_dly_s, vs_dly_s, de_dly_s, x_dly_s} = dly_s;

    // Bar index from the aligned column; the last bar takes any remainder
    assign bar_q_s   = x_dly_s / BAR_W;
    assign bar_idx_s = (bar_q_s >= BAR_MAX) ? 3'd7 : bar_q_s[2:0];

    if (PIX_W == 16) begin : g_bar565
        assign bar_s = bar_rgb565(bar_idx_s);
    end else begin : g_bar888
        assign bar_s = bar_rgb888(bar_idx_s);
    end

    // Output colour selection, forced to zero in blanking
    always_comb begin
        vga_rgb_d = '0;
        if (de_dly_s) begin
            case (active_mode_q)
                MODE_PASS:  vga_rgb_d = pixel_data;
                MODE_BARS:  vga_rgb_d = bar_s;
                MODE_FILL:  vga_rgb_d = fill_q;
                MODE_BLACK: vga_rgb_d = '0;
                default:    vga_rgb_d = '0;
            endcase
        end else begin
            vga_rgb_d = '0;
        end
    end

    // Output registers, mutually aligned
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs_q  <= ~HS_POL;
            vga_vs_q  <= ~VS_POL;
            vga_de_q  <= 1'b0;
            vga_rgb_q <= '0;
        end else begin
            vga_hs_q  <= hs_dly_s;
            vga_vs_q  <= vs_dly_s;
            vga_de_q  <= de_dly_s;
            vga_rgb_q <= vga_rgb_d;
        end
    end

    assign data_req    = data_req_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_de      = vga_de_q;
    assign vga_rgb     = vga_rgb_q;

endmodule
